// File: rtl/nanov_fetch_if.sv
// SPI flash bus between the fetch stage (master) and the external flash (slave).
interface nanov_fetch_if;
    logic spi_select;
    logic spi_clk_out;
    logic spi_mosi;
    logic spi_miso;

    modport master (
        output spi_select,
        output spi_clk_out,
        output spi_mosi,
        input  spi_miso
    );

    modport slave (
        input  spi_select,
        input  spi_clk_out,
        input  spi_mosi,
        output spi_miso
    );
endinterface

// File: rtl/nanov_fetch.sv
// nanoV fetch/sequencer: reads each instruction from SPI flash (READ 0x03), then drives
// the core's cycle/counter/serial-pc inputs and updates PC at the end of the instruction.
module nanov_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned ADDR_BITS = 24
) (
    input  logic          clk,
    input  logic          rst,
    nanov_fetch_if.master spi,
    output logic [31:0]   instr,
    output logic [2:0]    cycle,
    output logic [4:0]    counter,
    output logic          pc,
    input  logic          branch,
    input  logic [31:0]   data_in,
    output logic          exec_active
);
    localparam logic [31:0] Nop      = 32'h0000_0013;
    localparam logic [31:0] ResetPc  = {RESET_PC[31:2], 2'b00};
    localparam int unsigned TxBits   = 8 + ADDR_BITS;
    localparam logic [5:0]  AddrLast = 6'(ADDR_BITS - 1);

    typedef enum logic [2:0] {StDesel, StCmd, StAddr, StData, StExec} state_e;

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [TxBits-1:0] tx_q, tx_d;
    logic [31:0]       rx_q, rx_d;
    logic [31:0]       instr_q, instr_d;
    logic [5:0]        bit_q, bit_d;
    logic              sclk_q, sclk_d;
    logic [2:0]        cycle_q, cycle_d;
    logic [4:0]        counter_q, counter_d;
    logic              branch_pending_q, branch_pending_d;
    logic              multi_cycle;
    logic              exec_end;

    // JAL, JALR and conditional branches need a second cycle for the target.
    assign multi_cycle = (instr_q[6:2] == 5'b11011) || (instr_q[6:2] == 5'b11001) ||
                         (instr_q[6:2] == 5'b11000);
    assign exec_end    = (state_q == StExec) && (counter_q == 5'd31) &&
                         (cycle_q == (multi_cycle ? 3'd1 : 3'd0));

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        tx_d             = tx_q;
        rx_d             = rx_q;
        instr_d          = instr_q;
        bit_d            = bit_q;
        sclk_d           = 1'b0;
        cycle_d          = cycle_q;
        counter_d        = counter_q;
        branch_pending_d = branch_pending_q;

        unique case (state_q)
            StDesel: begin
                tx_d    = {8'h03, pc_q[ADDR_BITS-1:0]};
                bit_d   = 6'd0;
                state_d = StCmd;
            end
            StCmd, StAddr, StData: begin
                sclk_d = ~sclk_q;
                // MISO is captured on the edge where the SPI clock rises.
                if (!sclk_q && state_q == StData) begin
                    rx_d = {rx_q[30:0], spi.spi_miso};
                end
                // Bit boundary: SPI clock falls, MOSI advances.
                if (sclk_q) begin
                    tx_d  = {tx_q[TxBits-2:0], 1'b0};
                    bit_d = bit_q + 6'd1;
                    if (state_q == StCmd && bit_q == 6'd7) begin
                        state_d = StAddr;
                        bit_d   = 6'd0;
                    end else if (state_q == StAddr && bit_q == AddrLast) begin
                        state_d = StData;
                        bit_d   = 6'd0;
                    end else if (state_q == StData && bit_q == 6'd31) begin
                        state_d   = StExec;
                        bit_d     = 6'd0;
                        instr_d   = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
                        counter_d = 5'd0;
                        cycle_d   = 3'd0;
                    end
                end
            end
            StExec: begin
                if (branch) begin
                    branch_pending_d = 1'b1;
                end
                if (exec_end) begin
                    state_d          = StDesel;
                    counter_d        = 5'd0;
                    cycle_d          = 3'd0;
                    instr_d          = Nop;
                    branch_pending_d = 1'b0;
                    pc_d             = (branch_pending_q || branch) ?
                                       {data_in[31:1], 1'b0} : pc_q + 32'd4;
                end else begin
                    counter_d = counter_q + 5'd1;
                    if (counter_q == 5'd31) begin
                        cycle_d = cycle_q + 3'd1;
                    end
                end
            end
            default: state_d = StDesel;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= StDesel;
            pc_q             <= ResetPc;
            tx_q             <= '0;
            rx_q             <= '0;
            instr_q          <= Nop;
            bit_q            <= 6'd0;
            sclk_q           <= 1'b0;
            cycle_q          <= 3'd0;
            counter_q        <= 5'd0;
            branch_pending_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            tx_q             <= tx_d;
            rx_q             <= rx_d;
            instr_q          <= instr_d;
            bit_q            <= bit_d;
            sclk_q           <= sclk_d;
            cycle_q          <= cycle_d;
            counter_q        <= counter_d;
            branch_pending_q <= branch_pending_d;
        end
    end

    assign spi.spi_select  = !(state_q == StCmd || state_q == StAddr || state_q == StData);
    assign spi.spi_clk_out = sclk_q;
    assign spi.spi_mosi    = (state_q == StCmd || state_q == StAddr) ? tx_q[TxBits-1] : 1'b0;
    assign instr           = instr_q;
    assign cycle           = cycle_q;
    assign counter         = counter_q;
    assign pc              = pc_q[counter_q];
    assign exec_active     = (state_q == StExec);
endmodule

// File: tb/tb_nanov_fetch.sv
// Self-checking bench for nanov_fetch: behavioural SPI flash, table-driven and random
// instruction sequences, and reset aborts mid-fetch / mid-exec.
module tb_nanov_fetch;
    localparam logic [31:0] Nop = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic [2:0]  cycle;
    logic [4:0]  counter;
    logic        pc;
    logic        branch;
    logic [31:0] data_in;
    logic        exec_active;

    nanov_fetch_if bus ();

    nanov_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .spi         (bus),
        .instr       (instr),
        .cycle       (cycle),
        .counter     (counter),
        .pc          (pc),
        .branch      (branch),
        .data_in     (data_in),
        .exec_active (exec_active)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural SPI flash (mode 0) ----------------
    logic [31:0] flash_word = Nop;
    logic [31:0] fl_rx      = '0;
    logic [7:0]  fl_cmd     = '0;
    logic [23:0] fl_addr    = '1;
    int          fl_cnt     = 0;
    logic        sclk_prev  = 1'b0;
    logic        mosi_prev  = 1'b0;
    int          mosi_viol  = 0;

    always @(negedge clk) begin
        if (bus.spi_select) begin
            fl_cnt       = 0;
            sclk_prev    = 1'b0;
            fl_cmd       = '0;
            fl_addr      = '1;
            bus.spi_miso = 1'b0;
        end else begin
            if (bus.spi_clk_out && bus.spi_mosi !== mosi_prev) mosi_viol++;
            if (bus.spi_clk_out && !sclk_prev) begin
                if (fl_cnt < 32) fl_rx = {fl_rx[30:0], bus.spi_mosi};
                fl_cnt++;
                if (fl_cnt == 32) begin
                    fl_cmd  = fl_rx[31:24];
                    fl_addr = fl_rx[23:0];
                end
            end else if (!bus.spi_clk_out && sclk_prev) begin
                // Data byte k is flash_word[8k+7:8k], each byte MSB first.
                if (fl_cnt >= 32 && fl_cnt < 64)
                    bus.spi_miso = flash_word[8 * ((fl_cnt - 32) / 8) + 7 - ((fl_cnt - 32) % 8)];
            end
            sclk_prev = bus.spi_clk_out;
        end
        mosi_prev = bus.spi_mosi;
    end

    // ---------------- reference model ----------------
    function automatic int model_n(input logic [31:0] w);
        if (w[6:2] == 5'b11011 || w[6:2] == 5'b11001 || w[6:2] == 5'b11000) return 2;
        return 1;
    endfunction

    function automatic logic [31:0] model_next(input logic [31:0] cur, input bit taken,
                                               input logic [31:0] tgt);
        return taken ? (tgt & 32'hFFFF_FFFE) : cur + 32'd4;
    endfunction

    logic [31:0] exp_pc;

    // Runs one instruction starting from the DESEL clock (sampled on a negedge).
    task automatic do_instr(input logic [31:0] word, input int br_idx,
                            input logic [31:0] target, input int exp_n,
                            input logic [31:0] exp_next);
        int k = 0;
        int low = 0;
        int i = 0;
        int errs = 0;
        logic [7:0]  got_cmd = '0;
        logic [23:0] got_addr = '1;
        flash_word = word;
        data_in    = target;
        branch     = 1'b0;
        check("desel_select", 32'(bus.spi_select), 32'd1);
        check("idle_instr", instr, Nop);
        while (!exec_active && k < 400) begin
            @(negedge clk);
            k++;
            if (!bus.spi_select) begin
                low++;
                got_cmd  = fl_cmd;
                got_addr = fl_addr;
            end
        end
        check("fetch_latency", 32'(k), 32'd129);
        check("select_low_clks", 32'(low), 32'd128);
        check("flash_cmd", 32'(got_cmd), 32'h03);
        check("flash_addr", 32'(got_addr), {8'h0, exp_pc[23:0]});
        check("exec_instr", instr, word);
        while (exec_active && i < 100) begin
            if (instr !== word || counter !== 5'(i % 32) || cycle !== 3'(i / 32) ||
                pc !== exp_pc[i % 32] || bus.spi_select !== 1'b1) errs++;
            branch = (i == br_idx);
            @(negedge clk);
            i++;
        end
        branch = 1'b0;
        check("exec_clks", 32'(i), 32'(32 * exp_n));
        check("exec_trace_errs", 32'(errs), 32'd0);
        check("end_instr_nop", instr, Nop);
        check("end_counter_cycle", {24'h0, cycle, counter}, 32'd0);
        exp_pc = exp_next;
    endtask

    typedef struct {
        logic [31:0] word;
        int          br_idx;
        logic [31:0] target;
        int          n;
        logic [31:0] next_pc;
    } vec_t;

    vec_t tbl[8];

    initial begin
        // Hand-derived sequence starting at PC 0.
        tbl[0] = '{32'h0010_0513, -1, 32'h0000_0000, 1, 32'h0000_0004};
        tbl[1] = '{32'h0080_006F,  0, 32'h0000_0010, 2, 32'h0000_0010};
        tbl[2] = '{32'h0000_0063, -1, 32'hDEAD_0000, 2, 32'h0000_0014};
        tbl[3] = '{32'h0000_0063, 31, 32'h0000_0103, 2, 32'h0000_0102};
        tbl[4] = '{32'h0000_00E7, 63, 32'h7FFF_FFFD, 2, 32'h7FFF_FFFC};
        tbl[5] = '{32'h1234_50B7,  5, 32'h0000_0041, 1, 32'h0000_0040};
        tbl[6] = '{32'h0080_006F, 40, 32'hFFFF_FFFD, 2, 32'hFFFF_FFFC};
        tbl[7] = '{32'h0000_0013, -1, 32'h5555_5555, 1, 32'h0000_0000};

        rst     = 1'b1;
        branch  = 1'b0;
        data_in = '0;
        repeat (3) @(negedge clk);
        check("rst_select", 32'(bus.spi_select), 32'd1);
        check("rst_sclk_mosi", {30'h0, bus.spi_clk_out, bus.spi_mosi}, 32'd0);
        check("rst_instr", instr, Nop);
        check("rst_cyc_cnt_pc", {23'h0, cycle, counter, pc}, 32'd0);
        check("rst_exec_active", 32'(exec_active), 32'd0);
        rst    = 1'b0;
        exp_pc = 32'h0;

        for (int t = 0; t < 8; t++)
            do_instr(tbl[t].word, tbl[t].br_idx, tbl[t].target, tbl[t].n, tbl[t].next_pc);

        for (int r = 0; r < 16; r++) begin
            logic [31:0] w;
            logic [31:0] tgt;
            int n;
            int bi;
            case ($urandom_range(0, 3))
                0:       w = {$urandom() >> 7, 7'h6F};
                1:       w = {$urandom() >> 7, 7'h67};
                2:       w = {$urandom() >> 7, 7'h63};
                default: w = $urandom();
            endcase
            tgt = $urandom();
            n   = model_n(w);
            bi  = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 32 * n - 1));
            do_instr(w, bi, tgt, n, model_next(exp_pc, bi >= 0, tgt));
        end

        // Reset during the DATA phase (bit 40 of the fetch).
        flash_word = 32'hFFFF_FFFF;
        repeat (81) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midfetch_select", 32'(bus.spi_select), 32'd1);
        check("midfetch_instr", instr, Nop);
        check("midfetch_sclk_mosi", {30'h0, bus.spi_clk_out, bus.spi_mosi}, 32'd0);
        rst    = 1'b0;
        exp_pc = 32'h0;
        do_instr(32'h0000_0093, -1, 32'h0, 1, 32'h4);

        // Reset during EXEC of a two-cycle instruction.
        begin
            int k = 0;
            flash_word = 32'h0080_006F;
            while (!exec_active && k < 400) begin
                @(negedge clk);
                k++;
            end
            check("midexec_reached", 32'(exec_active), 32'd1);
            repeat (40) @(negedge clk);
            branch = 1'b1;
            rst    = 1'b1;
            @(negedge clk);
            branch = 1'b0;
            check("midexec_instr", instr, Nop);
            check("midexec_state", {23'h0, cycle, counter, exec_active}, 32'd0);
            rst    = 1'b0;
            exp_pc = 32'h0;
            do_instr(32'h0000_0063, -1, 32'h0, 2, 32'h4);
            do_instr(32'h0000_0013, -1, 32'h0, 1, 32'h8);
        end

        check("mosi_stable_while_sclk_high", 32'(mosi_viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/nanov_fetch.md
Name: nanov_fetch

Overview:
- Instruction fetch and sequencing stage directly upstream of the nanoV core.
- Owns the program counter and reads each 32-bit instruction from an external SPI flash with the READ command (0x03).
- Presents the instruction to the core, then drives the core's `cycle`, `counter` and serial `pc` inputs for the instruction's execution cycles.
- At the end of each instruction, loads the branch target from the core's `data_out` (when `branch` was flagged) or advances PC by 4.

Parameters:
- RESET_PC, 0, PC loaded on reset (bits [1:0] forced to 0).
- ADDR_BITS, 24, number of address bits sent to flash; PC[ADDR_BITS-1:0] is transmitted MSB first.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-high.
- spi_select  output  1  flash chip select, active-low.
- spi_clk_out  output  1  SPI clock, mode 0.
- spi_mosi  output  1  serial data to flash.
- spi_miso  input  1  serial data from flash.
- instr  output  32  instruction presented to the core.
- cycle  output  3  execution cycle index.
- counter  output  5  bit index within the current cycle.
- pc  output  1  serial PC bit: PC[counter] while executing.
- branch  input  1  core's branch flag.
- data_in  input  32  core's data_out; holds the branch target at end of instruction.
- exec_active  output  1  high while in EXEC.

Behaviour:
- States and transitions:
  - DESEL (1 clk): spi_select=1 → CMD.
  - CMD (8 bits, 0x03) → ADDR (ADDR_BITS bits, PC MSB first) → DATA (32 bits) → EXEC → DESEL.
- Reset:
  - State DESEL, PC=RESET_PC.
  - Outputs: spi_select=1, spi_clk_out=0, spi_mosi=0, instr=0x00000013 (NOP), cycle=0, counter=0, pc=RESET_PC[0], exec_active=0, branch_pending=0.
  - Reset mid-fetch or mid-exec aborts the transaction on the next edge; no partial instruction is ever presented.
- SPI timing:
  - One SPI bit per 2 clk; spi_clk_out toggles every clk while select is low.
  - spi_mosi changes only while spi_clk_out=0.
  - spi_miso is sampled on the clk edge where spi_clk_out rises.
  - spi_select is low throughout CMD, ADDR and DATA; high in DESEL and EXEC.
- Byte order:
  - Flash returns byte0 first, each byte MSB first.
  - instr = {byte3, byte2, byte1, byte0}.
  - Assembly uses a shift register; instr changes only on entry to EXEC.
- Outside EXEC, instr holds NOP so the core performs no architectural write.
- EXEC:
  - counter increments every clk from 0 to 31, then wraps to 0 while cycle increments.
  - Number of cycles N, decided from fetched opcode:
    - instr[6:2]=11011 (JAL), 11001 (JALR) or 11000 (branch): N=2.
    - All other opcodes: N=1.
  - EXEC ends on the clk where cycle=N-1 and counter=31.
  - On that end edge: counter=0, cycle=0, instr=NOP.
- pc output = PC[counter] combinationally; PC is constant during EXEC.
- Branch capture:
  - branch_pending sets whenever branch=1 in EXEC.
  - branch is ignored outside EXEC.
  - branch_pending clears on EXEC end.
- PC update, on the EXEC end edge:
  - If branch_pending (or branch=1 on that edge): PC = {data_in[31:1], 1'b0} & ~32'h3 is NOT applied; PC = data_in with bit0 cleared.
  - Otherwise PC = PC+4, wrapping modulo 2^32.
- Latency per instruction: 1 (DESEL) + 2*(8+ADDR_BITS+32) + 32*N clk. With defaults this is 129+32N.
- exec_active is asserted exactly on the clks where counter/cycle are valid for the core.

Test Plan:
- Reset with RESET_PC=0 → after DESEL, MOSI carries 0x03 then 24 zero bits; select low for 128 clk; first EXEC starts at clk 129.
- Flash returns bytes 13 05 10 00 → instr=0x00100513 in EXEC; N=1; 32 EXEC clks; next fetch address 0x000004; pc output equals PC[counter] each clk.
- JAL fetched (0x0080006F) with branch pulsed at cycle 0/counter 0 and data_in=0x00000010 at end → cycle reaches 1; 64 EXEC clks; next fetch address 0x000010.
- BEQ with branch never asserted → N=2; PC advances by 4. BEQ with branch at cycle 0/counter 31 and data_in=0x00000103 → next PC 0x00000102.
- rst asserted at bit 40 of a fetch → next clk: select=1, instr=NOP, PC=RESET_PC; after release, fetch restarts from the CMD byte.
- PC=0xFFFFFFFC with no branch → next PC 0x00000000; flash address 0x000000.
